demux_bits_deser: RTL and testbench

//  Serial-to-parallel demultiplexer: steers a 1-bit input stream, one bit per accepted beat, into

---
 rtl/demux_bits_deser_pkg.sv | 14 +
 rtl/demux_bits_dec.sv | 21 ++
 rtl/demux_bits_deser.sv | 110 +++++++++++
 tb/tb_demux_bits_deser.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/demux_bits_deser_pkg.sv
// Shared definitions for the serial-to-parallel lane demultiplexer: FSM state
// encodings and default geometry.
package demux_bits_deser_pkg;

    localparam int DMX_WIDTH_DEF = 4;
    localparam int DMX_SEL_W_DEF = 2;

    typedef enum logic [1:0] {
        DMX_FILL   = 2'd0,
        DMX_HOLD   = 2'd1,
        DMX_PARITY = 2'd2
    } dmx_state_t;

endpackage

// File: rtl/demux_bits_dec.sv
// One-hot lane-enable decoder: raises the enable of the lane selected by the
// lane counter when a bit is being accepted.
module demux_bits_dec #(
    parameter int WIDTH = 4,
    parameter int SEL_W = 2
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [WIDTH-1:0] lane_en
);

    always_comb begin
        lane_en = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (en && (sel == SEL_W'(i))) begin
                lane_en[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_bits_deser.sv
// Serial bit stream -> WIDTH-lane word with valid/ready on both sides.
// Define DEMUX_PARITY_EN to add a trailing even-parity beat and out_err.
module demux_bits_deser
    import demux_bits_deser_pkg::*;
#(
    parameter int WIDTH = DMX_WIDTH_DEF,
    parameter int SEL_W = DMX_SEL_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    input  logic             in_flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_bits,
    output logic [SEL_W-1:0] out_sel,
    output logic             out_err
);

    dmx_state_t       state, state_n;
    logic [SEL_W-1:0] cnt;
    logic             accept;
    logic             last_lane;
    logic [WIDTH-1:0] lane_en;

    // Flush wins over a coincident data beat, so it never counts as an accept.
    assign in_ready  = !reset && ((state == DMX_FILL) || (state == DMX_PARITY));
    assign accept    = in_valid && in_ready && !in_flush;
    assign last_lane = (cnt == SEL_W'(WIDTH - 1));
    assign out_valid = (state == DMX_HOLD);
    assign out_sel   = cnt;

    demux_bits_dec #(
        .WIDTH(WIDTH),
        .SEL_W(SEL_W)
    ) u_dec (
        .sel    (cnt),
        .en     (accept && (state == DMX_FILL)),
        .lane_en(lane_en)
    );

    always_comb begin
        state_n = state;
        case (state)
            DMX_FILL: begin
                if (accept && last_lane) begin
`ifdef DEMUX_PARITY_EN
                    state_n = DMX_PARITY;
`else
                    state_n = DMX_HOLD;
`endif
                end
            end
            DMX_PARITY: begin
                if (in_flush) begin
                    state_n = DMX_FILL;
                end else if (accept) begin
                    state_n = DMX_HOLD;
                end
            end
            DMX_HOLD: begin
                if (out_ready) begin
                    state_n = DMX_FILL;
                end
            end
            default: state_n = DMX_FILL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= DMX_FILL;
            cnt      <= '0;
            out_bits <= '0;
        end else begin
            state <= state_n;
            if ((state != DMX_HOLD) && in_flush) begin
                cnt      <= '0;
                out_bits <= '0;
            end else if ((state == DMX_FILL) && accept) begin
                cnt <= last_lane ? '0 : cnt + 1'b1;
                for (int i = 0; i < WIDTH; i++) begin
                    if (lane_en[i]) begin
                        out_bits[i] <= in_bit;
                    end
                end
            end else if ((state == DMX_HOLD) && out_ready) begin
                out_bits <= '0;
            end
        end
    end

`ifdef DEMUX_PARITY_EN
    // Even parity: data bits plus parity bit must XOR to zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_err <= 1'b0;
        end else if ((state == DMX_PARITY) && accept) begin
            out_err <= (^out_bits) ^ in_bit;
        end else if ((state == DMX_HOLD) && out_ready) begin
            out_err <= 1'b0;
        end
    end
`else
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_demux_bits_deser.sv
// Self-checking bench for demux_bits_deser (WIDTH=4); the parity scenarios are
// compiled in when DEMUX_PARITY_EN is defined.
module tb_demux_bits_deser;

    localparam int WIDTH = 4;
    localparam int SEL_W = 2;

    logic             clock = 1'b0;
    logic             reset, in_valid, in_ready, in_bit, in_flush;
    logic             out_valid, out_ready, out_err;
    logic [WIDTH-1:0] out_bits;
    logic [SEL_W-1:0] out_sel;

    int total = 0;
    int bad   = 0;

    demux_bits_deser #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_bit   (in_bit),
        .in_flush (in_flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_bits (out_bits),
        .out_sel  (out_sel),
        .out_err  (out_err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic beat(input logic b);
        in_valid = 1'b1;
        in_bit   = b;
        tick();
        in_valid = 1'b0;
    endtask

    // Parity beat (only meaningful with the parity feature); err=1 sends a wrong parity bit.
    task automatic parity_beat(input logic [WIDTH-1:0] w, input logic err);
`ifdef DEMUX_PARITY_EN
        beat((^w) ^ err);
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; in_flush = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        total++; if (out_bits !== 4'b0000) begin bad++; $display("FAIL rst_out_bits got=%b exp=0000", out_bits); end
        total++; if (out_sel !== 2'd0) begin bad++; $display("FAIL rst_out_sel got=%0d exp=0", out_sel); end
        total++; if (out_err !== 1'b0) begin bad++; $display("FAIL rst_out_err got=%b exp=0", out_err); end
        reset = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_basic_word();
        logic [WIDTH-1:0] w = 4'b1101;
        for (int i = 0; i < WIDTH; i++) begin
            beat(w[i]);
            total++;
            if (out_sel !== SEL_W'((i + 1) % WIDTH)) begin
                bad++; $display("FAIL basic_sel[%0d] got=%0d exp=%0d", i, out_sel, (i + 1) % WIDTH);
            end
        end
        parity_beat(w, 1'b0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
        total++; if (out_bits !== 4'b1101) begin bad++; $display("FAIL basic_bits got=%b exp=1101", out_bits); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_in_ready got=%b exp=0", in_ready); end
    endtask

    task automatic test_hold();
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_bit   = 1'($urandom);
            tick();
            total++;
            if (out_valid !== 1'b1 || out_bits !== 4'b1101 || in_ready !== 1'b0 || out_sel !== 2'd0) begin
                bad++;
                $display("FAIL hold[%0d] got v=%b bits=%b rdy=%b sel=%0d exp v=1 bits=1101 rdy=0 sel=0",
                         c, out_valid, out_bits, in_ready, out_sel);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || out_bits !== 4'b0000 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL hold_release got v=%b bits=%b rdy=%b exp v=0 bits=0000 rdy=1",
                     out_valid, out_bits, in_ready);
        end
    endtask

    task automatic test_flush();
        logic [WIDTH-1:0] w = 4'b1010;
        beat(1'b1);
        beat(1'b1);
        total++; if (out_bits !== 4'b0011 || out_sel !== 2'd2) begin
            bad++; $display("FAIL flush_pre got bits=%b sel=%0d exp bits=0011 sel=2", out_bits, out_sel);
        end
        in_flush = 1'b1;
        beat(1'b0);
        in_flush = 1'b0;
        total++; if (out_bits !== 4'b0000 || out_sel !== 2'd0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL flush got bits=%b sel=%0d v=%b exp bits=0000 sel=0 v=0", out_bits, out_sel, out_valid);
        end
        for (int i = 0; i < WIDTH; i++) beat(w[i]);
        parity_beat(w, 1'b0);
        total++; if (out_valid !== 1'b1 || out_bits !== 4'b1010) begin
            bad++; $display("FAIL flush_word got v=%b bits=%b exp v=1 bits=1010", out_valid, out_bits);
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_word();
        logic [WIDTH-1:0] w = 4'b1111;
        beat(1'b1);
        beat(1'b0);
        beat(1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (out_bits !== 4'b0000 || out_sel !== 2'd0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL midrst got bits=%b sel=%0d v=%b exp bits=0000 sel=0 v=0", out_bits, out_sel, out_valid);
        end
        for (int i = 0; i < WIDTH; i++) beat(w[i]);
        parity_beat(w, 1'b0);
        total++; if (out_valid !== 1'b1 || out_bits !== 4'b1111) begin
            bad++; $display("FAIL midrst_word got v=%b bits=%b exp v=1 bits=1111", out_valid, out_bits);
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    // Random gaps on both sides; the reference is simply the list of accepted bits.
    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            logic q[$];
            logic [WIDTH-1:0] exp_w;
            logic inj;
            int guard = 0;
            while (q.size() < WIDTH && guard < 200) begin
                logic v = 1'($urandom_range(0, 1));
                logic b = 1'($urandom);
                in_valid = v;
                in_bit   = b;
                tick();
                guard++;
                if (v) q.push_back(b);
                total++;
                if (out_sel !== SEL_W'(q.size() % WIDTH)) begin
                    bad++; $display("FAIL rnd_sel w%0d got=%0d exp=%0d", n, out_sel, q.size() % WIDTH);
                end
            end
            in_valid = 1'b0;
            total++; if (guard >= 200) begin bad++; $display("FAIL rnd_budget w%0d got=%0d exp<200", n, guard); end
            exp_w = '0;
            for (int i = 0; i < q.size(); i++) exp_w[i] = q[i];
            inj = 1'($urandom);
            parity_beat(exp_w, inj);
            for (int c = 0; c < int'($urandom_range(0, 3)); c++) begin
                in_valid = 1'b1; in_bit = 1'($urandom);
                tick();
            end
            in_valid = 1'b0;
            total++;
            if (out_valid !== 1'b1 || out_bits !== exp_w) begin
                bad++; $display("FAIL rnd_word w%0d got v=%b bits=%b exp v=1 bits=%b", n, out_valid, out_bits, exp_w);
            end
`ifdef DEMUX_PARITY_EN
            total++; if (out_err !== inj) begin bad++; $display("FAIL rnd_err w%0d got=%b exp=%b", n, out_err, inj); end
`else
            total++; if (out_err !== 1'b0) begin bad++; $display("FAIL rnd_err w%0d got=%b exp=0", n, out_err); end
`endif
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            total++;
            if (out_valid !== 1'b0 || out_bits !== 4'b0000 || out_err !== 1'b0) begin
                bad++; $display("FAIL rnd_release w%0d got v=%b bits=%b err=%b exp v=0 bits=0000 err=0",
                                n, out_valid, out_bits, out_err);
            end
        end
    endtask

`ifdef DEMUX_PARITY_EN
    task automatic test_parity();
        logic [WIDTH-1:0] w = 4'b1101;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < WIDTH; i++) beat(w[i]);
            total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                bad++; $display("FAIL par_wait%0d got v=%b rdy=%b exp v=0 rdy=1", k, out_valid, in_ready);
            end
            beat(k == 0 ? 1'b1 : 1'b0);
            total++; if (out_valid !== 1'b1 || out_bits !== 4'b1101 || out_err !== (k == 1)) begin
                bad++; $display("FAIL par%0d got v=%b bits=%b err=%b exp v=1 bits=1101 err=%0d",
                                k, out_valid, out_bits, out_err, k);
            end
            out_ready = 1'b1; tick(); out_ready = 1'b0;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_word();
        test_hold();
        test_flush();
        test_reset_mid_word();
`ifdef DEMUX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
